// File: rtl/pe_pkg.sv
// Shared constants and fixed-point helpers for the PE convolution front end.
// Q(W-FRAC).FRAC signed data, 3x3 kernel, N_CONV lanes.
package pe_pkg;

  localparam int N_CONV = 8;
  localparam int W      = 16;
  localparam int FRAC   = 8;
  localparam int ADDR_W = 10;
  localparam int K      = 3;
  localparam int ACC_W  = 2 * W + 4;
  localparam int SUM_W  = W + $clog2(N_CONV);

  // Clamp a wide signed value into the W-bit output range.
  function automatic logic signed [W-1:0] sat_w(
    input logic signed [ACC_W-1:0] v
  );
    if (v[ACC_W-1:W-1] == '0 || v[ACC_W-1:W-1] == '1)
      return v[W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/pe_convolver_lane.sv
// One convolver lane: 3x3 window line buffer, 9-tap filter register
// and a saturating fixed-point MAC.
module pe_convolver_lane
  import pe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_line,
  input  logic                shift_filter,
  input  logic                mac_en,
  input  logic                lb_clear,
  input  logic [ADDR_W-1:0]   row_length,
  input  logic signed [W-1:0] pixel,
  input  logic signed [W-1:0] weight,
  output logic signed [W-1:0] mac_out
);

  logic signed [W-1:0] win  [K][K];
  logic signed [W-1:0] filt [K*K];
  logic signed [W-1:0] row1_mem [2**ADDR_W];
  logic signed [W-1:0] row0_mem [2**ADDR_W];

  logic [ADDR_W-1:0]   wp, cnt, dly, rd_addr;
  logic signed [W-1:0] row1_tap, row0_tap;

  // Each row delay holds row_length-3 words; the window holds the other 9.
  assign dly     = row_length - ADDR_W'(K);
  assign rd_addr = wp - dly;

  // Entries written before the last clear are masked off by the count.
  always_comb begin
    row1_tap = '0;
    row0_tap = '0;
    if (dly == '0) begin
      row1_tap = win[2][0];
      row0_tap = win[1][0];
    end else if (cnt >= dly) begin
      row1_tap = row1_mem[rd_addr];
      row0_tap = row0_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (shift_line && !lb_clear) begin
      row1_mem[wp] <= win[2][0];
      row0_mem[wp] <= win[1][0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || lb_clear) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= '0;
      cnt <= '0;
      wp  <= '0;
    end else if (shift_line) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          win[r][c] <= win[r][c+1];
      win[2][2] <= pixel;
      win[1][2] <= row1_tap;
      win[0][2] <= row0_tap;
      if (cnt != '1)
        cnt <= cnt + 1'b1;
      wp <= wp + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K * K; k++)
        filt[k] <= '0;
    end else if (shift_filter) begin
      for (int k = 0; k < K * K - 1; k++)
        filt[k] <= filt[k+1];
      filt[K*K-1] <= weight;
    end
  end

  logic signed [2*W-1:0]   prod [K*K];
  logic signed [ACC_W-1:0] acc, scaled;

  always_comb begin
    acc = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        prod[r*K+c] = (2*W)'(win[r][c]) * (2*W)'(filt[r*K+c]);
        acc = acc + ACC_W'(prod[r*K+c]);
      end
    scaled = acc >>> FRAC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mac_out <= '0;
    else if (mac_en)
      mac_out <= sat_w(scaled);
  end

endmodule

// File: rtl/pe_conv_core.sv
// PE multiply-accumulate front end: N_CONV convolver lanes feeding a
// single-stage saturating adder tree over the enabled lanes.
module pe_conv_core
  import pe_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CONV-1:0]            shifting_line,
  input  logic [N_CONV-1:0]            shifting_filter,
  input  logic [N_CONV-1:0]            mac_enable,
  input  logic                         line_buffer_reset,
  input  logic [ADDR_W-1:0]            row_length,
  input  logic [N_CONV-1:0][W-1:0]     input_line,
  input  logic [N_CONV-1:0][W-1:0]     input_filter,
  output logic [N_CONV-1:0][W-1:0]     output_mac,
  output logic [W-1:0]                 adder_tree_out
);

  for (genvar i = 0; i < N_CONV; i++) begin : g_lane
    pe_convolver_lane u_lane (
      .clk          (clk),
      .rst          (rst),
      .shift_line   (shifting_line[i]),
      .shift_filter (shifting_filter[i]),
      .mac_en       (mac_enable[i]),
      .lb_clear     (line_buffer_reset),
      .row_length   (row_length),
      .pixel        (input_line[i]),
      .weight       (input_filter[i]),
      .mac_out      (output_mac[i])
    );
  end

  logic [N_CONV-1:0]       en_d;
  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CONV; i++)
      if (en_d[i])
        sum = sum + SUM_W'($signed(output_mac[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d           <= '0;
      adder_tree_out <= '0;
    end else begin
      en_d <= mac_enable;
      if (|en_d)
        adder_tree_out <= sat_w(ACC_W'(sum));
    end
  end

endmodule

// File: tb/tb_pe_conv_core.sv
// Directed bench for pe_conv_core with a scoreboard of expected MAC
// and adder-tree results.
module tb_pe_conv_core;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       shifting_line;
  logic [7:0]       shifting_filter;
  logic [7:0]       mac_enable;
  logic             line_buffer_reset;
  logic [9:0]       row_length;
  logic [7:0][15:0] input_line;
  logic [7:0][15:0] input_filter;
  logic [7:0][15:0] output_mac;
  logic [15:0]      adder_tree_out;

  pe_conv_core dut (
    .clk               (clk),
    .rst               (rst),
    .shifting_line     (shifting_line),
    .shifting_filter   (shifting_filter),
    .mac_enable        (mac_enable),
    .line_buffer_reset (line_buffer_reset),
    .row_length        (row_length),
    .input_line        (input_line),
    .input_filter      (input_filter),
    .output_mac        (output_mac),
    .adder_tree_out    (adder_tree_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              tag;
    int                 lane;
    logic signed [15:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] wts [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic signed [15:0] obs,
                       input logic signed [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_all_line(input logic [15:0] v);
    for (int i = 0; i < 8; i++) input_line[i] = v;
  endtask

  task automatic load_filter(input logic [7:0] mask,
                             input logic [15:0] w [9]);
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < 8; i++) input_filter[i] = w[k];
      shifting_filter = mask;
      step();
    end
    shifting_filter = '0;
  endtask

  task automatic stream(input logic [7:0] mask, input logic [15:0] start,
                        input logic [15:0] inc, input int n);
    for (int s = 0; s < n; s++) begin
      set_all_line(start + 16'(s) * inc);
      shifting_line = mask;
      step();
    end
    shifting_line = '0;
  endtask

  task automatic mac_check(input string tag, input logic [7:0] mask,
                           input logic signed [15:0] lane_exp,
                           input logic signed [15:0] tree_exp);
    sb_t e;
    for (int i = 0; i < 8; i++)
      if (mask[i]) begin
        e.tag = tag; e.lane = i; e.exp = lane_exp;
        sbq.push_back(e);
      end
    e.tag = tag; e.lane = -1; e.exp = tree_exp;
    sbq.push_back(e);
    mac_enable = mask;
    step();
    mac_enable = '0;
    while (sbq.size() > 0 && sbq[0].lane >= 0) begin
      e = sbq.pop_front();
      check($sformatf("%s_mac%0d", e.tag, e.lane),
            output_mac[e.lane], e.exp);
    end
    step();
    e = sbq.pop_front();
    check($sformatf("%s_tree", e.tag), adder_tree_out, e.exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    shifting_line = '0;
    shifting_filter = '0;
    mac_enable = '0;
    line_buffer_reset = 1'b0;
    row_length = 10'd4;
    input_line = '0;
    input_filter = '0;
    step();
    step();
    for (int i = 0; i < 8; i++)
      check($sformatf("reset_mac%0d", i), output_mac[i], 16'sd0);
    check("reset_tree", adder_tree_out, 16'sd0);
    rst = 1'b0;
    step();

    // 9.0 = nine taps of 1.0 * 1.0
    for (int k = 0; k < 9; k++) wts[k] = 16'd256;
    load_filter(8'h01, wts);
    stream(8'h01, 16'd256, 16'd0, 12);
    mac_check("basic", 8'h01, 16'sd2304, 16'sd2304);

    // Only the centre tap: x[n - L - 1]
    line_buffer_reset = 1'b1;
    step();
    line_buffer_reset = 1'b0;
    row_length = 10'd5;
    for (int k = 0; k < 9; k++) wts[k] = 16'd0;
    wts[4] = 16'd256;
    load_filter(8'h02, wts);
    stream(8'h02, 16'd0, 16'd256, 13);
    mac_check("index", 8'h02, 16'((12 - 5 - 1) * 256),
              16'((12 - 5 - 1) * 256));
    check("hold_mac0", output_mac[0], 16'sd2304);

    for (int k = 0; k < 9; k++) wts[k] = 16'h7FFF;
    load_filter(8'h04, wts);
    stream(8'h04, 16'h7FFF, 16'd0, 13);
    mac_check("sat_pos", 8'h04, 16'sh7FFF, 16'sh7FFF);
    for (int k = 0; k < 9; k++) wts[k] = 16'h8000;
    load_filter(8'h04, wts);
    mac_check("sat_neg", 8'h04, 16'sh8000, 16'sh8000);

    // All lanes to 256 via the newest tap at the minimum row length
    line_buffer_reset = 1'b1;
    step();
    line_buffer_reset = 1'b0;
    row_length = 10'd3;
    for (int k = 0; k < 9; k++) wts[k] = 16'd0;
    wts[8] = 16'd256;
    load_filter(8'hFF, wts);
    stream(8'hFF, 16'd256, 16'd0, 1);
    mac_check("all", 8'hFF, 16'sd256, 16'sd2048);
    mac_check("mask", 8'h05, 16'sd256, 16'sd512);
    step();
    step();
    check("tree_hold", adder_tree_out, 16'sd512);
    check("mac1_hold", output_mac[1], 16'sd256);

    // Clear wins over a simultaneous shift; filter survives
    line_buffer_reset = 1'b1;
    shifting_line = 8'hFF;
    set_all_line(16'd256);
    step();
    line_buffer_reset = 1'b0;
    shifting_line = '0;
    mac_check("lbr", 8'h01, 16'sd0, 16'sd0);
    stream(8'h01, 16'd256, 16'd0, 9);
    mac_check("lbr_restore", 8'h01, 16'sd256, 16'sd256);

    // Asynchronous reset between edges while streaming
    shifting_line = 8'hFF;
    set_all_line(16'd256);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_mac0", output_mac[0], 16'sd0);
    check("async_mac1", output_mac[1], 16'sd0);
    check("async_tree", adder_tree_out, 16'sd0);
    shifting_line = '0;
    step();
    rst = 1'b0;
    step();
    stream(8'h01, 16'd256, 16'd0, 1);
    mac_check("no_filter", 8'h01, 16'sd0, 16'sd0);
    for (int k = 0; k < 9; k++) wts[k] = 16'd0;
    wts[7] = 16'd256;
    load_filter(8'h01, wts);
    mac_check("restart0", 8'h01, 16'sd0, 16'sd0);
    stream(8'h01, 16'd256, 16'd0, 1);
    mac_check("restart1", 8'h01, 16'sd256, 16'sd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_conv_core.md
Name: pe_conv_core

Overview:
- Multiply-accumulate front end of one processing element.
- Holds N_CONV parallel 3x3 convolver lanes. Each lane has its own line buffer, filter register and MAC.
- A registered adder tree sums the enabled lanes into one partial sum.
- The output feeds the PE's feedback adder, bias stage and non-linearity stages, which are outside this block.

Parameters:
- N_CONV, 8, number of convolver lanes (one per input buffer).
- W, 16, data/weight/output width; signed two's complement.
- FRAC, 8, fractional bits (Q(W-FRAC).FRAC fixed point).
- ADDR_W, 10, row_length width; maximum row length is 2^ADDR_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- shifting_line  in  N_CONV  per-lane: push input_line[i] into lane i's line buffer.
- shifting_filter  in  N_CONV  per-lane: push input_filter[i] into lane i's filter register.
- mac_enable  in  N_CONV  per-lane: compute the MAC this cycle.
- line_buffer_reset  in  1  synchronous clear of all line buffers.
- row_length  in  ADDR_W  image row length in samples; must be >=3 and stable while streaming.
- input_line  in  N_CONV x W  per-lane pixel stream.
- input_filter  in  N_CONV x W  per-lane weight stream.
- output_mac  out  N_CONV x W  per-lane registered MAC result.
- adder_tree_out  out  W  registered sum of enabled lanes.

Behaviour:
- Line buffer (per lane):
  - A sample stream x[n], where n is the count of shifts since the last clear.
  - Window W[r][c], r,c in 0..2, equals x[n-(2-r)*row_length-(2-c)]. Any index below 0 reads 0.
  - Storage is 2*row_length+3 words, as RAM or shift register.
  - line_buffer_reset takes priority over shifting_line and zeroes all window data in every lane.
- Filter (per lane):
  - A 9-entry shift register, updated when shifting_filter[i] is high.
  - Weights loaded in order k=0..8; after 9 shifts, weight k multiplies W[k/3][k%3].
  - The filter is not cleared by line_buffer_reset; it is cleared only by rst.
- MAC (per lane):
  - When mac_enable[i] is high, output_mac[i] <= sat_W( (sum over 9 taps of W[r][c]*F) >>> FRAC ).
  - Products are full 2W; accumulate at 2W+4 bits.
  - The arithmetic shift floors toward -inf.
  - Saturate to [-2^(W-1), 2^(W-1)-1].
  - When mac_enable[i] is low, output_mac[i] holds its value.
  - The MAC uses pre-edge window and filter values. A simultaneous shift affects the next MAC only.
- Adder tree:
  - en_d = mac_enable delayed one cycle, so it aligns with output_mac.
  - When |en_d is high, adder_tree_out <= sat_W( sum of output_mac[i] where en_d[i]=1 ). Disabled lanes contribute 0; the sum is accumulated at W+log2(N_CONV) bits.
  - When |en_d is low, adder_tree_out holds.
  - Single register stage; pipelining is not allowed.
- Latency: mac_enable edge to output_mac is 1 cycle; to adder_tree_out is 2 cycles; fully pipelined at 1 result per cycle.
- Reset: rst clears all outputs, output_mac, adder_tree_out, filters, line buffers, sample counts and en_d to 0. Reset may occur mid-stream; after release, the stream restarts at n=0.

Decomposition:
- Shared package pe_pkg: W, FRAC, ADDR_W, N_CONV, the K=3 kernel constant, and a saturate function.
- One sub-module, pe_convolver_lane: line buffer, filter and MAC. It is instantiated N_CONV times in a generate loop.
- The adder tree is inline in pe_conv_core.

Test Plan:
- Basic 3x3 window:
  - Setup: row_length=4; lane 0 loaded with 9 weights of 256 (1.0); stream 12 samples of 256; then pulse mac_enable[0].
  - Expect: output_mac[0]=2304 (9.0) one cycle later, and adder_tree_out=2304 one cycle after that.
- Window indexing:
  - Setup: row_length=5; stream x[n]=n*256 for n=0..12; weights are 256 at k=4 only, 0 elsewhere.
  - Expect: MAC = x[12-5-1] = 1536.
- Saturation:
  - Setup: all window samples and weights 0x7FFF.
  - Expect: output_mac=32767. With weights 0x8000, expect -32768.
- Adder-tree masking:
  - Setup: every lane holds output 256; assert mac_enable=8'b0000_0101.
  - Expect: adder_tree_out=512 two cycles later. With mac_enable=0, it holds 512.
- line_buffer_reset and simultaneous events:
  - Setup: assert line_buffer_reset together with shifting_line, then MAC.
  - Expect: result 0 while the filter is retained. Then 9 more shifts restore the nonzero result.
- Asynchronous reset mid-stream:
  - Setup: assert rst between clock edges.
  - Expect: outputs go to 0 immediately. After release, a MAC with no new filter load returns 0.
